somador_serial_ctrl: RTL and testbench
======================================

Name: somador_serial_ctrl

Overview:
Bit-serial adder sequencer. It adds two N-bit operands by reusing a single somador1bit instance for N clock cycles, LSB first, with a carry flop between cycles. It replaces the N-instance ripple adder where area matters more than latency. A start/busy/done handshake lets a lab top-level or FSM request one sum at a time.

Parameters:
N, 5, operand width in bits; the result is N+1 bits wide.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock
start  input  1  request pulse; sampled only in IDLE
a  input  N  operand 1; captured in the cycle start is accepted
b  input  N  operand 2; captured in the cycle start is accepted
busy  output  1  high while an addition is in progress (SOMA and FIM)
done  output  1  one-cycle pulse; s is valid from this cycle onward
s  output  N+1  registered sum; s[N] is the final carry-out

Behaviour:
- Reset (reset_n=0 at a rising edge): state=IDLE, busy=0, done=0, s=0, internal shift registers, carry and counter all 0. Reset takes priority over every other event, including mid-operation; an in-flight sum is discarded and done is not asserted.
- States and outputs:
  - IDLE: busy=0, done=0.
  - SOMA: busy=1, done=0.
  - FIM: busy=1, done=1.
- IDLE with start=1:
  - load sh_a<=a, sh_b<=b, carry<=0, cnt<=0.
  - go to SOMA.
  - If start=0, stay in IDLE.
- SOMA, each cycle:
  - somador1bit(sh_a[0], sh_b[0], carry) produces sum bit and cout.
  - r <= {sum, r[N-1:1]} (shift right; sum enters the MSB).
  - sh_a and sh_b shift right by 1, zero-filled.
  - carry <= cout; cnt <= cnt+1.
  - When cnt==N-1, also load s <= {cout, sum, r[N-1:1]} and go to FIM.
- FIM: lasts exactly one cycle, then returns to IDLE.
- s update rule: s changes only on the SOMA->FIM edge, so it never shows partial results. It holds its value through IDLE until the next FIM or a reset.
- Latency: start accepted at edge t; done is high in the cycle after edge t+N, i.e. N+1 cycles after start. Throughput is one sum per N+2 cycles.
- Handshake rules:
  - start is ignored while busy=1, including during FIM.
  - a and b may change freely after the accept edge.
  - start held high continuously produces back-to-back sums, each accepted on the first IDLE cycle.
- Arithmetic: unsigned. s = a + b exactly, range 0..2^(N+1)-2; no overflow is possible.
- cnt width is clog2(N) bits. It never wraps inside SOMA because the exit happens at N-1.

Decomposition:
- Package somador_pkg holds:
  - state encoding constants IDLE=2'b00, SOMA=2'b01, FIM=2'b10;
  - default width constant N_PADRAO=5.
- Encoding 2'b11 is illegal and must recover to IDLE on the next edge.
- One sub-module: the existing somador1bit, instantiated once, port order (a, b, cin, cout, s). It is purely combinational; all state lives in somador_serial_ctrl.

Test Plan:
- a=5, b=3, start pulse -> busy high for 6 cycles; done pulse 6 cycles after start with s=6'd8; s holds 8 afterwards.
- a=31, b=31 -> s=6'b111110 (62) at done. a=31, b=1 -> s=6'b100000 (32), confirming the final carry lands in s[5].
- a=0, b=0 -> s=0 at done. Separately, a=0, b=31 with the prior result 62 still on s -> s stays 62 until done, then changes to 31.
- Start pulses at cycles 2 and 4 after an accepted start -> ignored; exactly one done. start held high for 20 cycles -> done every 7 cycles, each sum correct for the a/b present at its accept cycle.
- reset_n=0 for one edge at cycle 3 of SOMA -> next cycle state=IDLE, busy=0, s=0, no done pulse. A new start then yields the correct sum.
- Force the state register to 2'b11 -> IDLE on the next edge with busy=0, done=0.

Source files
------------

// File: rtl/somador_pkg.sv
// Shared definitions for the bit-serial adder: sequencer state encoding and default width.
package somador_pkg;

  localparam int N_PADRAO = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SOMA = 2'b01,
    FIM  = 2'b10
  } estado_t;

endpackage

// File: rtl/somador1bit.sv
// Combinational 1-bit full adder, reused once per bit by the serial sequencer.
module somador1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic s
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/somador_serial_ctrl.sv
// Bit-serial N-bit adder: one full adder used for N cycles, LSB first, with a carry flop
// between cycles and a start/busy/done handshake around it.
module somador_serial_ctrl
  import somador_pkg::*;
#(
  parameter int N = N_PADRAO
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N:0]   s
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  estado_t       state;
  estado_t       next_state;
  logic [N-1:0]  sh_a;
  logic [N-1:0]  sh_b;
  logic [N-1:0]  r;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          soma_bit;
  logic          cout;
  logic          last;

  somador1bit u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .cout (cout),
    .s    (soma_bit)
  );

  assign last = (cnt == CW'(N - 1));

  always_comb begin
    next_state = IDLE;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: next_state = start ? SOMA : IDLE;
      SOMA: begin
        busy       = 1'b1;
        next_state = last ? FIM : SOMA;
      end
      FIM: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      // 2'b11 is unreachable; fall back to IDLE with outputs low
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // s is written only when the last bit is produced, so it never shows a partial sum
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      r     <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        SOMA: begin
          r     <= {soma_bit, r[N-1:1]};
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            s <= {cout, soma_bit, r[N-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Self-checking bench for somador_serial_ctrl: vector table, corner-case sequences and
// random transactions compared against a cycle-count model of the handshake.
module tb_somador_serial_ctrl;
  import somador_pkg::*;

  localparam int N = 5;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [N-1:0] a       = '0;
  logic [N-1:0] b       = '0;
  logic         busy;
  logic         done;
  logic [N:0]   s;

  somador_serial_ctrl #(.N(N)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .s       (s)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: remaining busy cycles, pending sum, visible sum
  int m_cnt     = 0;
  int m_pend    = 0;
  int m_s       = 0;
  int mod_dones = 0;
  int dut_dones = 0;

  typedef struct {
    int a;
    int b;
    int exp_s;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input logic st, input logic [N-1:0] va, input logic [N-1:0] vb,
                      input logic rn);
    start   = st;
    a       = va;
    b       = vb;
    reset_n = rn;
    @(posedge clock);
    if (!rn) begin
      m_cnt = 0;
      m_s   = 0;
    end else if (m_cnt == 0) begin
      if (st) begin
        m_cnt  = N + 1;
        m_pend = int'(va) + int'(vb);
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        m_s = m_pend;
        mod_dones++;
      end
    end
    #1;
    if (done === 1'b1) dut_dones++;
    chk("busy", 32'(busy), 32'(m_cnt > 0));
    chk("done", 32'(done), 32'(m_cnt == 1));
    chk("s", 32'(s), 32'(m_s));
  endtask

  task automatic run_txn(input logic [N-1:0] va, input logic [N-1:0] vb, input int exp_s);
    int lat;
    lat = 0;
    step(1'b1, va, vb, 1'b1);
    for (int i = 1; i <= N + 3; i++) begin
      step(1'b0, N'($urandom), N'($urandom), 1'b1);
      if (done === 1'b1) begin
        lat = i + 1;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(N + 1));
    chk("vec_s", 32'(s), 32'(exp_s));
    step(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int m0;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    vecs[0] = '{5, 3, 8};
    vecs[1] = '{31, 31, 62};
    vecs[2] = '{31, 1, 32};
    vecs[3] = '{0, 0, 0};
    vecs[4] = '{31, 31, 62};
    vecs[5] = '{0, 31, 31};
    vecs[6] = '{16, 15, 31};

    // Reset state
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, 5'd7, 5'd7, 1'b0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s", 32'(s), 32'd0);

    // Vector table; the 62 -> 31 pair shows s holding until done
    for (int i = 0; i < 7; i++) begin
      run_txn(N'(vecs[i].a), N'(vecs[i].b), vecs[i].exp_s);
    end

    // Extra start pulses while busy are ignored
    d0 = dut_dones;
    step(1'b1, 5'd7, 5'd9, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 5'd1, 5'd1, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 5'd2, 5'd2, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    chk("ign_dones", 32'(dut_dones - d0), 32'd1);
    chk("ign_s", 32'(s), 32'd16);

    // start held high: back-to-back sums every N+2 cycles
    d0 = dut_dones;
    m0 = mod_dones;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, N'($urandom), N'($urandom), 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, '0, 1'b1);
    end
    chk("held_dones", 32'(dut_dones - d0), 32'd3);
    chk("held_model", 32'(dut_dones - d0), 32'(mod_dones - m0));

    // Reset in the third SOMA cycle discards the sum
    step(1'b1, 5'd12, 5'd9, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    d0 = dut_dones;
    step(1'b0, '0, '0, 1'b0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    chk("mid_rst_s", 32'(s), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, '0, 1'b1);
    end
    chk("mid_rst_nodone", 32'(dut_dones - d0), 32'd0);
    run_txn(5'd12, 5'd9, 21);

    // Illegal state encoding recovers to IDLE
    force dut.state = estado_t'(2'b11);
    #1;
    release dut.state;
    #1;
    chk("ill_busy_now", 32'(busy), 32'd0);
    step(1'b0, '0, '0, 1'b1);
    chk("ill_state", 32'(dut.state), 32'(IDLE));
    chk("ill_s_kept", 32'(s), 32'd21);
    run_txn(5'd19, 5'd22, 41);

    // Random transactions with random idle gaps
    for (int k = 0; k < 25; k++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        step(1'b0, N'($urandom), N'($urandom), 1'b1);
      end
      ra = N'($urandom);
      rb = N'($urandom);
      run_txn(ra, rb, int'(ra) + int'(rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
